// File: rtl/divider.sv
// Signed 32-bit sequential divider: non-restoring magnitude division, one quotient bit per clock,
// followed by a sign-fix cycle. A result pulse appears 33 edges after the start edge.
module divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   b_mag;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;

    logic [WIDTH-1:0]   a_abs_c;
    logic [WIDTH-1:0]   b_abs_c;
    logic [WIDTH:0]     shifted_c;
    logic [WIDTH:0]     step_c;
    logic [WIDTH-1:0]   rem_fix_c;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a start strobe overrides whatever is in flight
    always_comb begin
        state_next = state;
        if (ctrl_DIV) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Magnitudes: the most negative value maps onto its unsigned twin without loss
    always_comb begin
        a_abs_c   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        b_abs_c   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        shifted_c = {rem[WIDTH-1:0], quo[WIDTH-1]};
        step_c    = rem[WIDTH] ? (shifted_c + {1'b0, b_mag}) : (shifted_c - {1'b0, b_mag});
        // Final remainder lies in [0, |B|), so the low WIDTH bits carry the restore exactly
        rem_fix_c = rem[WIDTH] ? (rem[WIDTH-1:0] + b_mag) : rem[WIDTH-1:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            b_mag          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state_next == DONE);
            if (ctrl_DIV) begin
                quo      <= a_abs_c;
                b_mag    <= b_abs_c;
                rem      <= '0;
                cnt      <= '0;
                sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                sign_r   <= data_operandA[WIDTH-1];
                div_zero <= (data_operandB == '0);
            end else begin
                case (state)
                    RUN: begin
                        rem <= step_c;
                        quo <= {quo[WIDTH-2:0], ~step_c[WIDTH]};
                        cnt <= cnt + CNT_W'(1);
                    end
                    FIX: begin
                        if (div_zero) begin
                            data_result    <= '0;
                            data_remainder <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= sign_q ? -quo : quo;
                            data_remainder <= sign_r ? -rem_fix_c : rem_fix_c;
                            data_exception <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: expected results are queued at each start and
// matched (value and latency) against every data_resultRDY pulse.
module tb_divider;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;

    exp_t        sb[$];
    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [31:0] last_res;

    divider #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.cyc = 0;
        if (b == 32'd0) begin
            e.res = 32'd0; e.rem = 32'd0; e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000; e.rem = 32'd0; e.exc = 1'b0;
        end else begin
            e.res = 32'($signed(a) / $signed(b));
            e.rem = 32'($signed(a) % $signed(b));
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Compare every result pulse against the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset && data_resultRDY) begin
            if (sb.size() == 0) begin
                check_eq("spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", data_result, e.res);
                check_eq("remainder", data_remainder, e.rem);
                check_eq("exception", 32'(data_exception), 32'(e.exc));
                check_eq("latency", 32'(cyc), 32'(e.cyc));
                last_res = e.res;
            end
        end
    end

    // Drive one start strobe; any still-pending operation is aborted by it
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        if (sb.size() != 0) void'(sb.pop_back());
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        e     = model(a, b);
        e.cyc = cyc + 34;
        sb.push_back(e);
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check_eq("hold_result", data_result, last_res);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            check_eq("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_result"}, data_result, 32'd0);
        check_eq({tag, "_remainder"}, data_remainder, 32'd0);
        check_eq({tag, "_exception"}, 32'(data_exception), 32'd0);
        check_eq({tag, "_rdy"}, 32'(data_resultRDY), 32'd0);
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks      = 0;
        n_pass        = 0;
        last_res      = 32'd0;
        reset         = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b1;

        start(32'd100, 32'd7);                 drain();
        start(-32'sd100, 32'd7);               drain();
        start(32'd100, -32'sd7);               drain();
        start(32'd5, 32'd0);                   drain();
        start(32'h8000_0000, 32'hFFFF_FFFF);   drain();
        start(32'h8000_0000, 32'd2);           drain();

        // Restart mid-run: only the second operation reports
        start(32'd1000, 32'd3);
        repeat (9) @(negedge clock);
        start(32'd9, 32'd4);
        drain();

        // Strobe held for three edges: last sampled operands win
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd11; data_operandB = 32'd2;
        @(negedge clock);
        data_operandA = 32'd500; data_operandB = 32'd0;
        @(negedge clock);
        data_operandA = -32'sd77; data_operandB = 32'd8;
        e     = model(data_operandA, data_operandB);
        e.cyc = cyc + 34;
        sb.push_back(e);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($signed(32'($urandom_range(0, 20))) - 10) : $urandom;
            if (i % 2 == 1) ra = 32'($signed(32'($urandom_range(0, 4000))) - 2000);
            start(ra, rb);
            drain();
        end

        // Reset mid-operation discards the operation
        start(32'd50, 32'd5);
        repeat (19) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        last_res = 32'd0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check_zero_outputs("postreset");
        start(32'd50, 32'd5);
        drain();
        repeat (40) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
